// File: rtl/irq_agg.sv
// irq_agg: interrupt aggregator with per-source polarity, edge/level
// capture, optional 2-flop synchronizers and a native-bus register file.
module irq_agg #(
  parameter int NSRC = 32,
  parameter int SYNC = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSRC-1:0] src_i,
  input  logic            mem_valid_i,
  input  logic [31:0]     mem_addr_i,
  input  logic [31:0]     mem_wdata_i,
  input  logic [3:0]      mem_wstrb_i,
  output logic            mem_ready_o,
  output logic [31:0]     mem_rdata_o,
  output logic [31:0]     irq_o
);

  localparam logic [31:0] MASK = 32'((64'd1 << NSRC) - 64'd1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t      state;
  state_t      state_n;
  logic        load;
  logic        wr;
  logic [2:0]  addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic [31:0] rdata_n;

  logic [31:0] pend;
  logic [31:0] ena;
  logic [31:0] mode;
  logic [31:0] pol;
  logic [31:0] pend_n;
  logic [31:0] ena_n;
  logic [31:0] mode_n;
  logic [31:0] pol_n;
  logic [31:0] w1c;
  logic [31:0] swset;
  logic [31:0] bmask;
  logic [31:0] wbits;

  logic [31:0] src_w;
  logic [31:0] lvl;
  logic [31:0] synced;
  logic [31:0] dly;
  logic [31:0] flip;
  logic [31:0] rise;
  logic        unused_ok;

  assign unused_ok = ^{mem_addr_i[31:5], mem_addr_i[1:0]};

  assign src_w = 32'(src_i) & MASK;
  assign lvl   = src_w ^ pol;

  // A polarity write inverts the whole level history of the affected
  // bits, so the new polarity never looks like a fresh edge.
  assign flip = pol ^ pol_n;

  generate
    if (SYNC != 0) begin : g_sync
      logic [31:0] s1;
      logic [31:0] s2;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s1 <= '0;
          s2 <= '0;
        end else begin
          s1 <= lvl ^ flip;
          s2 <= s1 ^ flip;
        end
      end
      assign synced = s2;
    end else begin : g_direct
      assign synced = lvl;
    end
  endgenerate

  assign rise = synced & ~dly;

  assign wr    = (state == ACK) && (wstrb_q != 4'b0000);
  assign bmask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}},
                  {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
  assign wbits = wdata_q & bmask & MASK;

  always_comb begin
    ena_n  = ena;
    mode_n = mode;
    pol_n  = pol;
    w1c    = '0;
    swset  = '0;
    if (wr) begin
      unique case (1'b1)
        (addr_q == 3'd0): w1c    = wbits;
        (addr_q == 3'd1): ena_n  = (ena & ~bmask) | wbits;
        (addr_q == 3'd2): mode_n = (mode & ~bmask) | wbits;
        (addr_q == 3'd3): pol_n  = (pol & ~bmask) | wbits;
        (addr_q == 3'd5): swset  = wbits;
        default: ;
      endcase
    end
  end

  // Set sources (edge, SWSET) win over a same-cycle W1C.
  assign pend_n = ((mode & (rise | (pend & ~w1c)))
                 | (~mode & synced)
                 | swset) & MASK;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= '0;
      ena  <= '0;
      mode <= '0;
      pol  <= '0;
      dly  <= '0;
    end else begin
      pend <= pend_n;
      ena  <= ena_n;
      mode <= mode_n;
      pol  <= pol_n;
      dly  <= (synced ^ flip) & MASK;
    end
  end

  always_comb begin
    rdata_n = '0;
    unique case (1'b1)
      (mem_addr_i[4:2] == 3'd0): rdata_n = pend;
      (mem_addr_i[4:2] == 3'd1): rdata_n = ena;
      (mem_addr_i[4:2] == 3'd2): rdata_n = mode;
      (mem_addr_i[4:2] == 3'd3): rdata_n = pol;
      (mem_addr_i[4:2] == 3'd4): rdata_n = synced;
      default: rdata_n = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_valid_i) begin
          state_n = ACK;
          load    = 1'b1;
        end
      end
      ACK: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else if (load) begin
      addr_q  <= mem_addr_i[4:2];
      wdata_q <= mem_wdata_i;
      wstrb_q <= mem_wstrb_i;
      rdata_q <= rdata_n;
    end
  end

  // Reset during ACK suppresses the pending ready pulse.
  assign mem_ready_o = (state == ACK) && !rst_i;
  assign mem_rdata_o = mem_ready_o ? rdata_q : '0;
  assign irq_o       = pend & ena;

endmodule

// File: tb/tb_irq_agg.sv
// tb_irq_agg: directed plus randomized bench for irq_agg, checked by a
// scoreboard fed from a source-history reference model.
module tb_irq_agg;

  localparam int NSRC = 24;
  localparam logic [31:0] MASK = 32'h00FF_FFFF;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NSRC-1:0] src_i;
  logic            mem_valid_i;
  logic [31:0]     mem_addr_i;
  logic [31:0]     mem_wdata_i;
  logic [3:0]      mem_wstrb_i;
  logic            mem_ready_o;
  logic [31:0]     mem_rdata_o;
  logic [31:0]     irq_o;

  always #5 clk = ~clk;

  irq_agg #(.NSRC(NSRC), .SYNC(1)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .src_i(src_i),
    .mem_valid_i(mem_valid_i),
    .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o),
    .mem_rdata_o(mem_rdata_o),
    .irq_o(irq_o)
  );

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;
  bit   prev_ready = 1'b0;

  // Reference state: raw source samples plus register values.
  logic [31:0] m_pend = '0;
  logic [31:0] m_ena = '0;
  logic [31:0] m_mode = '0;
  logic [31:0] m_pol = '0;
  logic [31:0] m_irq = '0;
  logic [31:0] h [3];
  bit          m_ack = 1'b0;
  logic [2:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wstrb = '0;

  initial begin
    h[0] = '0;
    h[1] = '0;
    h[2] = '0;
  end

  // The conditioned level seen by the capture logic is the raw source two
  // samples back, viewed through the polarity currently programmed.
  always @(posedge clk) begin
    logic [31:0] sy, pv, bm, wb, w1c, sws, rd, n_ena, n_mode, n_pol;
    exp_t e;
    if (rst_i) begin
      m_pend = '0; m_ena = '0; m_mode = '0; m_pol = '0; m_irq = '0;
      h[0] = '0; h[1] = '0; h[2] = '0;
      m_ack = 1'b0;
      exp_q.delete();
    end else begin
      sy = (h[1] ^ m_pol) & MASK;
      pv = (h[2] ^ m_pol) & MASK;
      if (!m_ack && mem_valid_i) begin
        case (mem_addr_i[4:2])
          3'd0: rd = m_pend;
          3'd1: rd = m_ena;
          3'd2: rd = m_mode;
          3'd3: rd = m_pol;
          3'd4: rd = sy;
          default: rd = '0;
        endcase
        e.rd = (mem_wstrb_i == 4'b0000);
        e.data = rd;
        exp_q.push_back(e);
      end
      w1c = '0; sws = '0;
      n_ena = m_ena; n_mode = m_mode; n_pol = m_pol;
      if (m_ack && m_wstrb != 4'b0000) begin
        bm = '0;
        for (int b = 0; b < 4; b++)
          if (m_wstrb[b]) bm[b*8 +: 8] = 8'hFF;
        wb = m_wdata & bm & MASK;
        case (m_addr)
          3'd0: w1c = wb;
          3'd1: n_ena = (m_ena & ~bm) | wb;
          3'd2: n_mode = (m_mode & ~bm) | wb;
          3'd3: n_pol = (m_pol & ~bm) | wb;
          3'd5: sws = wb;
          default: ;
        endcase
      end
      for (int i = 0; i < NSRC; i++) begin
        if (m_mode[i])
          m_pend[i] = sws[i] | (sy[i] & ~pv[i]) | (m_pend[i] & ~w1c[i]);
        else
          m_pend[i] = sy[i] | sws[i];
      end
      m_ena = n_ena; m_mode = n_mode; m_pol = n_pol;
      if (m_ack) begin
        m_ack = 1'b0;
      end else if (mem_valid_i) begin
        m_ack = 1'b1;
        m_addr = mem_addr_i[4:2];
        m_wdata = mem_wdata_i;
        m_wstrb = mem_wstrb_i;
      end
      h[2] = h[1];
      h[1] = h[0];
      h[0] = 32'(src_i);
      m_irq = m_pend & m_ena;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      total++;
      if (irq_o !== m_irq) begin
        bad++;
        $display("FAIL irq t=%0t got=%h want=%h", $time, irq_o, m_irq);
      end
      if (mem_ready_o === 1'b1) begin
        total++;
        if (prev_ready) begin
          bad++;
          $display("FAIL ready_b2b t=%0t got=1 want=0", $time);
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ready_unexpected t=%0t got=1 want=0", $time);
        end else begin
          e = exp_q.pop_front();
          if (e.rd && mem_rdata_o !== e.data) begin
            bad++;
            $display("FAIL rdata t=%0t got=%h want=%h",
                     $time, mem_rdata_o, e.data);
          end
        end
      end else begin
        total++;
        if (mem_rdata_o !== 32'h0) begin
          bad++;
          $display("FAIL rdata_idle t=%0t got=%h want=0", $time, mem_rdata_o);
        end
      end
      prev_ready = (mem_ready_o === 1'b1);
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    int n;
    @(posedge clk); #1;
    mem_valid_i = 1'b1;
    mem_addr_i = a;
    mem_wdata_i = d;
    mem_wstrb_i = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mem_ready_o !== 1'b1 && n < 8);
    if (mem_ready_o !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL bus_timeout addr=%h got=0 want=1", a);
    end
    r = mem_rdata_o;
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, d, 4'hF, r);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    bus(a, 32'h0, 4'h0, r);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          cnt;
    int          idx;
    rst_i = 1'b1;
    src_i = '0;
    mem_valid_i = 1'b0;
    mem_addr_i = '0;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_irq", irq_o, 32'h0);
    check("rst_ready", 32'(mem_ready_o), 32'h0);
    check("rst_rdata", mem_rdata_o, 32'h0);
    @(posedge clk); #1 rst_i = 1'b0;

    rd(32'h0, r); check("pend_rst", r, 32'h0);
    rd(32'h4, r); check("ena_rst", r, 32'h0);

    wr(32'h4, 32'h20);
    wr(32'h8, 32'h20);
    @(posedge clk); #1 src_i[5] = 1'b1;
    repeat (3) @(negedge clk);
    check("edge5_early", irq_o, 32'h0);
    @(negedge clk);
    check("edge5_irq", irq_o, 32'h20);
    wr(32'h0, 32'h20);
    @(negedge clk);
    check("edge5_w1c", irq_o, 32'h0);

    wr(32'hC, 32'h1);
    repeat (4) @(negedge clk);
    rd(32'h0, r); check("lvl_pol_set", r, 32'h1);
    wr(32'h0, 32'h1);
    rd(32'h0, r); check("lvl_w1c", r, 32'h1);
    @(posedge clk); #1 src_i[0] = 1'b1;
    repeat (4) @(negedge clk);
    rd(32'h0, r); check("lvl_clear", r, 32'h0);

    wr(32'h8, 32'h28);
    @(posedge clk); #1 src_i[3] = 1'b1;
    wr(32'h0, 32'h8);
    rd(32'h0, r); check("set_wins", r, 32'h8);

    wr(32'h0, 32'h8);
    wr(32'h4, 32'h0);
    wr(32'h8, 32'h228);
    @(posedge clk); #1 src_i[9] = 1'b1;
    @(posedge clk); #1 src_i[9] = 1'b0;
    repeat (4) @(negedge clk);
    check("masked_irq", irq_o, 32'h0);
    rd(32'h0, r); check("pend9", r, 32'h200);
    wr(32'h4, 32'h200);
    @(negedge clk);
    check("ena9_irq", irq_o, 32'h200);

    wr(32'h8, 32'h628);
    wr(32'h14, 32'h400);
    rd(32'h0, r); check("swset", r, 32'h600);
    rd(32'h14, r); check("swset_rd0", r, 32'h0);

    wr(32'h4, 32'h0);
    bus(32'h4, 32'hFFFF_FFFF, 4'b0001, r);
    rd(32'h4, r); check("ena_byte", r, 32'hFF);
    rd(32'h1C, r); check("unmapped", r, 32'h0);
    wr(32'h18, 32'hFFFF_FFFF);
    rd(32'h18, r); check("unmapped_wr", r, 32'h0);
    wr(32'h4, 32'hFFFF_FFFF);
    rd(32'h4, r); check("ena_nsrc", r, MASK);

    @(posedge clk); #1;
    mem_valid_i = 1'b1;
    mem_addr_i = 32'h0;
    mem_wstrb_i = 4'h0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(mem_ready_o);
    end
    @(posedge clk); #1 mem_valid_i = 1'b0;
    check("ready_pulses", 32'(cnt), 32'd4);

    @(posedge clk); #1;
    mem_valid_i = 1'b1;
    mem_addr_i = 32'h4;
    mem_wdata_i = 32'hFF00;
    mem_wstrb_i = 4'hF;
    @(posedge clk); #1 rst_i = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(mem_ready_o), 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'h0;
    @(negedge clk);
    check("abort_irq", irq_o, 32'h0);
    rd(32'h4, r); check("abort_ena", r, 32'h0);

    for (int it = 0; it < 400; it++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, NSRC - 1);
        src_i[idx] = ~src_i[idx];
      end
      if ($urandom_range(0, 2) == 0) begin
        a = 32'($urandom_range(0, 7)) << 2;
        s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        d = $urandom;
        bus(a, d, s, r);
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
